fpu_bcd_conv_arbiter: RTL and testbench
=======================================

// Module: fpu_bcd_conv_arbiter
// PURPOSE
//  Shares one FPU_Binary_to_BCD converter between two requesters (port 0: FBSTP microcode path,
//  port 1: diagnostic/debug path). Round-robin arbitration with a valid/ready request and response
//  handshake. Holds converter enable high until done, then captures the result and enforces an
//  idle gap. A watchdog aborts conversions that never assert done.
// PARAMETERS
//  TIMEOUT_CYCLES  64  RUN cycles without cvt_done before abort (>=2)
//  GAP_CYCLES      2   cycles cvt_enable held low after each conversion (>=1)
// PORTS
//  clk            in   1   clock; all state on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  reqN_valid     in   1   requester N (N=0,1) has an operand
//  reqN_ready     out  1   arbiter accepts requester N this cycle
//  reqN_binary    in   64  magnitude to convert
//  reqN_sign      in   1   sign to place in BCD bit 79
//  rspN_valid     out  1   result for requester N available
//  rspN_ready     in   1   requester N consumes result
//  rspN_bcd       out  80  packed BCD result
//  rspN_error     out  1   converter error, or forced on timeout
//  rspN_timeout   out  1   conversion aborted by watchdog
//  cvt_enable     out  1   converter enable (registered)
//  cvt_binary     out  64  operand to converter (latched)
//  cvt_sign       out  1   sign to converter (latched)
//  cvt_bcd        in   80  converter result
//  cvt_done       in   1   converter completion
//  cvt_error      in   1   converter error flag
//  busy           out  1   state != IDLE
//  grant_id       out  1   requester owning current transaction
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; all outputs 0; cvt_enable drops immediately; last_grant=1.
//  States: IDLE -> RUN -> RESP -> GAP -> IDLE.
//  IDLE: reqN_ready = reqN_valid & (grant to N). Both valid: requester != last_grant wins, so req0
//   wins first after reset. Single valid: it wins. Accept edge: latch binary/sign into cvt_*,
//   set grant_id and last_grant, clear watchdog, go RUN.
//  RUN: cvt_enable=1 starting the cycle after accept. cvt_binary/cvt_sign stay stable. Watchdog
//   counts each RUN cycle.
//   - cvt_done=1 sampled: capture cvt_bcd/cvt_error into the granted rsp regs, timeout=0, go RESP.
//   - Watchdog == TIMEOUT_CYCLES-1 with no done: bcd=0, error=1, timeout=1, go RESP.
//   - Done and timeout on the same edge: done wins.
//  RESP: cvt_enable=0. rsp<grant>_valid=1 and data held stable until rsp<grant>_ready is sampled
//   high, then go GAP. The other rsp port stays 0.
//  GAP: cvt_enable=0 for exactly GAP_CYCLES cycles, then go IDLE. reqN_ready=0.
//  cvt_done while not in RUN: ignored. reqN_ready=0 in all states except IDLE.
//  Latency: accept edge k -> cvt_enable high from k+1. Done sampled at edge m -> rsp_valid high
//   from m+1. Response consumed at edge r -> ready can assert again at r+GAP_CYCLES+1.
//  Reset in any state: aborts the transaction. Pending response is lost; no rsp_valid after release.
// TESTING
//  Use the real FPU_Binary_to_BCD and a stub converter.
//  req0 binary=123 sign=0 -> single grant; rsp0_bcd=80'h00000000000000000123; error=0, timeout=0.
//  req0=456/sign1 and req1=999/sign0 in the same cycle ->
//   rsp0_bcd=80'h80000000000000000456 first, then rsp1_bcd=80'h00000000000000000999.
//  Both requesters valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
//  Stub never asserts done, TIMEOUT_CYCLES=16 -> rspN_timeout=1, error=1, bcd=0
//   after 16 RUN cycles; cvt_enable low in the next cycle.
//  rsp0_ready held low 5 cycles -> rsp0_valid and rsp0_bcd stable throughout;
//   cvt_enable low for exactly GAP_CYCLES after consume.
//  reset_n pulsed low mid-RUN -> cvt_enable=0 and busy=0 immediately; no rsp_valid;
//   next request (1 -> 80'h...01) converts correctly.

Source files
------------

// File: rtl/fpu_bcd_conv_arbiter.sv
// Round-robin sharing of one binary-to-BCD converter between two requesters.
// Ports: reqN_* operand handshake, rspN_* result handshake, cvt_* converter side, busy/grant_id status.
module fpu_bcd_conv_arbiter #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int GAP_CYCLES     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_binary,
   input  logic        req0_sign,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_binary,
   input  logic        req1_sign,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [79:0] rsp0_bcd,
   output logic        rsp0_error,
   output logic        rsp0_timeout,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [79:0] rsp1_bcd,
   output logic        rsp1_error,
   output logic        rsp1_timeout,
   output logic        cvt_enable,
   output logic [63:0] cvt_binary,
   output logic        cvt_sign,
   input  logic [79:0] cvt_bcd,
   input  logic        cvt_done,
   input  logic        cvt_error,
   output logic        busy,
   output logic        grant_id
);

   localparam int MAXC = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_t;

   state_t        state, state_nx;
   logic          last_grant;
   logic          sel;
   logic          accept;
   logic          rsp_take;
   logic          wd_exp;
   logic [CW-1:0] cnt;
   logic [79:0]   bcd_q [2];
   logic [1:0]    err_q;
   logic [1:0]    to_q;

   // With both requesting, the one not served last wins.
   always_comb begin
      if (req0_valid & req1_valid) sel = ~last_grant;
      else                         sel = req1_valid;
   end

   assign accept     = (state == IDLE) & (req0_valid | req1_valid);
   assign req0_ready = (state == IDLE) & req0_valid & ~sel;
   assign req1_ready = (state == IDLE) & req1_valid & sel;
   assign rsp_take   = (state == RESP) & (grant_id ? rsp1_ready : rsp0_ready);
   assign wd_exp     = (cnt == WD_LAST);
   assign busy       = (state != IDLE);

   assign rsp0_valid   = (state == RESP) & ~grant_id;
   assign rsp1_valid   = (state == RESP) & grant_id;
   assign rsp0_bcd     = bcd_q[0];
   assign rsp1_bcd     = bcd_q[1];
   assign rsp0_error   = err_q[0];
   assign rsp1_error   = err_q[1];
   assign rsp0_timeout = to_q[0];
   assign rsp1_timeout = to_q[1];

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = RUN;
         RUN:  if (cvt_done | wd_exp) state_nx = RESP;
         RESP: if (rsp_take) state_nx = GAP;
         GAP:  if (cnt == GAP_LAST) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cvt_enable <= 1'b0;
         cvt_binary <= '0;
         cvt_sign   <= 1'b0;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         bcd_q[0]   <= '0;
         bcd_q[1]   <= '0;
         err_q      <= '0;
         to_q       <= '0;
      end else begin
         // Enable tracks the RUN state one cycle early so it is a clean flop output.
         cvt_enable <= (state_nx == RUN);
         unique case (state)
            IDLE: begin
               if (accept) begin
                  cvt_binary <= sel ? req1_binary : req0_binary;
                  cvt_sign   <= sel ? req1_sign : req0_sign;
                  grant_id   <= sel;
                  last_grant <= sel;
                  cnt        <= '0;
               end
            end
            RUN: begin
               cnt <= cnt + CW'(1);
               // Done takes priority over a watchdog expiring on the same edge.
               if (cvt_done) begin
                  bcd_q[grant_id] <= cvt_bcd;
                  err_q[grant_id] <= cvt_error;
                  to_q[grant_id]  <= 1'b0;
               end else if (wd_exp) begin
                  bcd_q[grant_id] <= '0;
                  err_q[grant_id] <= 1'b1;
                  to_q[grant_id]  <= 1'b1;
               end
            end
            RESP: if (rsp_take) cnt <= '0;
            GAP:  cnt <= cnt + CW'(1);
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_bcd_conv_arbiter.sv
// Bench for fpu_bcd_conv_arbiter: stub converter, transaction-level model,
// per-cycle compare against the model plus directed literal checks.
module tb_fpu_bcd_conv_arbiter;

   localparam int TO = 16;
   localparam int GP = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [63:0] req0_binary = '0, req1_binary = '0;
   logic        req0_sign = 1'b0, req1_sign = 1'b0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [79:0] rsp0_bcd, rsp1_bcd;
   logic        rsp0_error, rsp1_error, rsp0_timeout, rsp1_timeout;
   logic        cvt_enable;
   logic [63:0] cvt_binary;
   logic        cvt_sign;
   logic [79:0] cvt_bcd;
   logic        cvt_done;
   logic        cvt_error;
   logic        busy, grant_id;

   fpu_bcd_conv_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_binary(req0_binary), .req0_sign(req0_sign),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_binary(req1_binary), .req1_sign(req1_sign),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_bcd(rsp0_bcd),
      .rsp0_error(rsp0_error), .rsp0_timeout(rsp0_timeout),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_bcd(rsp1_bcd),
      .rsp1_error(rsp1_error), .rsp1_timeout(rsp1_timeout),
      .cvt_enable(cvt_enable), .cvt_binary(cvt_binary), .cvt_sign(cvt_sign),
      .cvt_bcd(cvt_bcd), .cvt_done(cvt_done), .cvt_error(cvt_error),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // {error, bcd}: 19 decimal digits, sign in bit 79, error when >= 1e19.
   function automatic logic [80:0] conv(input logic [63:0] b, input logic s);
      logic [79:0] r;
      logic [63:0] v;
      r = '0;
      v = b;
      for (int i = 0; i < 19; i++) begin
         r[4*i +: 4] = 4'(v % 64'd10);
         v = v / 64'd10;
      end
      r[79] = s;
      return {(b >= 64'd10000000000000000000), r};
   endfunction

   // ---------------- stub converter ----------------
   bit stub_hang = 0;
   bit stub_spur = 0;
   int stub_lat_max = 3;
   int scnt = 0;
   int slat = 1;

   initial begin
      cvt_done  = 1'b0;
      cvt_bcd   = '0;
      cvt_error = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (cvt_enable) begin
            scnt++;
            if (!stub_hang && scnt == slat) begin
               {cvt_error, cvt_bcd} = conv(cvt_binary, cvt_sign);
               cvt_done = 1'b1;
            end else begin
               cvt_done = 1'b0;
            end
         end else begin
            scnt = 0;
            slat = $urandom_range(1, stub_lat_max);
            cvt_done = stub_spur && ($urandom_range(0, 3) == 0);
            cvt_bcd = {$urandom, $urandom, 16'($urandom)};
            cvt_error = 1'($urandom_range(0, 1));
         end
      end
   end

   // ---------------- transaction model ----------------
   bit          m_armed = 0;
   bit          m_txn, m_res, m_cons, m_last, m_g, m_err, m_to;
   int          m_run, m_gap;
   logic [63:0] m_bin;
   logic        m_sign;
   logic [79:0] m_bcd;

   function automatic bit winner(input bit v0, input bit v1, input bit last);
      if (v0 && v1) return !last;
      return v1;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            m_armed = 1; m_txn = 0; m_res = 0; m_cons = 0;
            m_last = 1; m_g = 0; m_run = 0; m_gap = 0;
            m_err = 0; m_to = 0; m_bcd = '0;
         end else if (!m_txn) begin
            if (req0_valid || req1_valid) begin
               m_g = winner(req0_valid, req1_valid, m_last);
               m_last = m_g;
               m_bin = m_g ? req1_binary : req0_binary;
               m_sign = m_g ? req1_sign : req0_sign;
               m_txn = 1; m_res = 0; m_cons = 0; m_run = 0;
            end
         end else if (!m_res) begin
            m_run++;
            if (cvt_done) begin
               {m_err, m_bcd} = conv(m_bin, m_sign);
               m_to = 0; m_res = 1;
            end else if (m_run == TO) begin
               m_bcd = '0; m_err = 1; m_to = 1; m_res = 1;
            end
         end else if (!m_cons) begin
            if (m_g ? rsp1_ready : rsp0_ready) begin
               m_cons = 1; m_gap = 0;
            end
         end else begin
            m_gap++;
            if (m_gap == GP) m_txn = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      bit w, e0v, e1v;
      forever begin
         @(negedge clk);
         if (reset_n && m_armed) begin
            w   = winner(req0_valid, req1_valid, m_last);
            e0v = m_txn && m_res && !m_cons && !m_g;
            e1v = m_txn && m_res && !m_cons && m_g;
            chk("busy", 80'(busy), 80'(m_txn));
            chk("cvt_enable", 80'(cvt_enable), 80'(m_txn && !m_res));
            chk("req0_ready", 80'(req0_ready), 80'(!m_txn && req0_valid && !w));
            chk("req1_ready", 80'(req1_ready), 80'(!m_txn && req1_valid && w));
            chk("rsp0_valid", 80'(rsp0_valid), 80'(e0v));
            chk("rsp1_valid", 80'(rsp1_valid), 80'(e1v));
            chk("grant_id", 80'(grant_id), 80'(m_g));
            if (m_txn && !m_res) begin
               chk("cvt_binary", 80'(cvt_binary), 80'(m_bin));
               chk("cvt_sign", 80'(cvt_sign), 80'(m_sign));
            end
            if (e0v) begin
               chk("rsp0_bcd", rsp0_bcd, m_bcd);
               chk("rsp0_error", 80'(rsp0_error), 80'(m_err));
               chk("rsp0_timeout", 80'(rsp0_timeout), 80'(m_to));
            end
            if (e1v) begin
               chk("rsp1_bcd", rsp1_bcd, m_bcd);
               chk("rsp1_error", 80'(rsp1_error), 80'(m_err));
               chk("rsp1_timeout", 80'(rsp1_timeout), 80'(m_to));
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int p);
      int n;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if ((p == 0) ? req0_ready : req1_ready) break;
         n++;
      end
      if (n >= 100) bound_fail("accept_wait");
   endtask

   task automatic wait_rsp(input int p, output logic [79:0] b, output logic e, output logic t);
      int n;
      n = 0;
      b = '0; e = 1'b0; t = 1'b0;
      while (n < 100) begin
         @(negedge clk);
         if (p == 0 && rsp0_valid) begin
            b = rsp0_bcd; e = rsp0_error; t = rsp0_timeout; break;
         end
         if (p == 1 && rsp1_valid) begin
            b = rsp1_bcd; e = rsp1_error; t = rsp1_timeout; break;
         end
         n++;
      end
      if (n >= 100) bound_fail("rsp_wait");
   endtask

   task automatic do_reset();
      tick();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [79:0] b, b0;
      logic        e, t;
      int          n, en_cnt, gap_low, ports[$];

      repeat (3) tick();
      chk("reset_enable", 80'(cvt_enable), 80'(0));
      chk("reset_busy", 80'(busy), 80'(0));
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset_busy", 80'(busy), 80'(0));
      chk("post_reset_rsp0", 80'(rsp0_valid), 80'(0));
      chk("post_reset_grant", 80'(grant_id), 80'(0));

      // single grant, 123
      tick();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_binary = 64'd123; req0_sign = 1'b0;
      wait_ready(0);
      tick();
      req0_valid = 1'b0;
      wait_rsp(0, b, e, t);
      chk("t1_bcd", b, 80'h00000000000000000123);
      chk("t1_err", 80'(e), 80'(0));
      chk("t1_to", 80'(t), 80'(0));

      // simultaneous requests right after reset: req0 first
      do_reset();
      req0_valid = 1'b1; req0_binary = 64'd456; req0_sign = 1'b1;
      req1_valid = 1'b1; req1_binary = 64'd999; req1_sign = 1'b0;
      n = 0;
      while (n < 100 && !rsp0_valid && !rsp1_valid) begin
         @(negedge clk);
         n++;
      end
      chk("t3_first_port0", 80'(rsp0_valid), 80'(1));
      chk("t3_first_bcd", rsp0_bcd, 80'h80000000000000000456);
      tick();
      req0_valid = 1'b0;
      wait_rsp(1, b, e, t);
      chk("t3_second_bcd", b, 80'h00000000000000000999);
      tick();
      req1_valid = 1'b0;

      // continuous contention: grants alternate
      repeat (4) tick();
      req0_valid = 1'b1; req0_binary = 64'd11; req0_sign = 1'b0;
      req1_valid = 1'b1; req1_binary = 64'd22; req1_sign = 1'b1;
      n = 0;
      while (n < 300 && ports.size() < 6) begin
         @(negedge clk);
         if (rsp0_valid) ports.push_back(0);
         if (rsp1_valid) ports.push_back(1);
         n++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (ports.size() < 6) bound_fail("t4_grants");
      else for (int i = 0; i < 6; i++) chk($sformatf("t4_grant%0d", i), 80'(ports[i]), 80'(i % 2));

      // watchdog
      repeat (6) tick();
      stub_hang = 1;
      req0_valid = 1'b1; req0_binary = 64'd77; req0_sign = 1'b0;
      wait_ready(0);
      tick();
      req0_valid = 1'b0;
      en_cnt = 0;
      n = 0;
      while (n < 100 && !rsp0_valid) begin
         @(negedge clk);
         if (cvt_enable) en_cnt++;
         n++;
      end
      chk("t5_run_cycles", 80'(en_cnt), 80'(16));
      chk("t5_timeout", 80'(rsp0_timeout), 80'(1));
      chk("t5_error", 80'(rsp0_error), 80'(1));
      chk("t5_bcd", rsp0_bcd, 80'h0);
      chk("t5_enable_low", 80'(cvt_enable), 80'(0));
      stub_hang = 0;

      // held response, then gap length
      repeat (4) tick();
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_binary = 64'd314159; req0_sign = 1'b0;
      wait_ready(0);
      tick();
      req0_valid = 1'b0;
      wait_rsp(0, b0, e, t);
      chk("t6_bcd", b0, 80'h00000000000000314159);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t6_hold_valid", 80'(rsp0_valid), 80'(1));
         chk("t6_hold_bcd", rsp0_bcd, 80'h00000000000000314159);
      end
      tick();
      rsp0_ready = 1'b1;
      req0_valid = 1'b1; req0_binary = 64'd5;
      @(posedge clk);
      gap_low = 0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (req0_ready) break;
         if (!cvt_enable) gap_low++;
         n++;
      end
      chk("t6_gap_cycles", 80'(gap_low), 80'(GP));
      tick();
      req0_valid = 1'b0;
      wait_rsp(0, b, e, t);
      chk("t6_next_bcd", b, 80'h5);

      // reset mid-RUN
      repeat (4) tick();
      stub_hang = 1;
      req1_valid = 1'b1; req1_binary = 64'd42; req1_sign = 1'b0;
      wait_ready(1);
      tick();
      req1_valid = 1'b0;
      tick();
      #1;
      reset_n = 1'b0;
      #1;
      chk("t7_enable_async", 80'(cvt_enable), 80'(0));
      chk("t7_busy_async", 80'(busy), 80'(0));
      tick();
      tick();
      reset_n = 1'b1;
      stub_hang = 0;
      repeat (3) tick();
      req1_valid = 1'b1; req1_binary = 64'd1; req1_sign = 1'b0;
      wait_ready(1);
      tick();
      req1_valid = 1'b0;
      wait_rsp(1, b, e, t);
      chk("t7_bcd", b, 80'h00000000000000000001);

      // randomized traffic, including spurious done and natural timeouts
      stub_lat_max = 18;
      stub_spur = 1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         req0_valid = ($urandom_range(0, 2) == 0);
         req1_valid = ($urandom_range(0, 2) == 0);
         req0_binary = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 999999));
         req1_binary = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 999999));
         req0_sign = 1'($urandom_range(0, 1));
         req1_sign = 1'($urandom_range(0, 1));
         rsp0_ready = ($urandom_range(0, 2) != 0);
         rsp1_ready = ($urandom_range(0, 2) != 0);
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (60) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
